multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM for the RV32I multicycle datapath. Holds only the state
// register; every output is decoded combinationally from the current state
// and the instruction/status inputs.
//
// Ports:
//   CLK, RST_N              clock, synchronous active-low reset
//   OP, FUNCT3, FUNCT7B5    fields of the registered instruction
//   ZERO                    ALU zero flag (branch condition)
//   MEM_READY               memory completes the current access this cycle
//   PC_WRITE, IR_WRITE      PC / instruction+OldPC register enables
//   ADR_SRC                 memory address mux (0 PC, 1 ALUOut)
//   MEM_WRITE, REG_WRITE    memory / register-file write enables
//   RESULT_SRC              00 ALUOut, 01 Data, 10 ALUResult
//   ALU_SRC_A               00 PC, 01 OldPC, 10 rd1
//   ALU_SRC_B               00 rd2, 01 ImmExt, 10 constant 4
//   IMM_SRC                 00 I, 01 S, 10 B, 11 J
//   ALU_CONTROL             000 add, 001 sub, 010 and, 011 or, 101 slt
//   RETIRE                  pulse on the last cycle of each instruction
//   ILLEGAL                 pulse in DECODE for an unsupported opcode
module multicycle_controller (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] OP,
    input  logic [2:0] FUNCT3,
    input  logic       FUNCT7B5,
    input  logic       ZERO,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic       ADR_SRC,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       REG_WRITE,
    output logic [1:0] RESULT_SRC,
    output logic [1:0] ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] IMM_SRC,
    output logic [2:0] ALU_CONTROL,
    output logic       RETIRE,
    output logic       ILLEGAL
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_e;

    state_e     state_q, state_d;
    state_e     st;
    logic [1:0] alu_op;

    // While reset is held the outputs decode as FETCH, so the selects show
    // their FETCH values even before the state register has been loaded.
    assign st = RST_N ? state_q : S_FETCH;

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and per-state control
    always_comb begin
        state_d    = state_q;
        PC_WRITE   = 1'b0;
        ADR_SRC    = 1'b0;
        MEM_WRITE  = 1'b0;
        IR_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        RESULT_SRC = 2'b00;
        ALU_SRC_A  = 2'b00;
        ALU_SRC_B  = 2'b00;
        alu_op     = 2'b00;
        RETIRE     = 1'b0;
        ILLEGAL    = 1'b0;
        unique case (st)
            S_FETCH: begin
                ALU_SRC_B  = 2'b10;
                RESULT_SRC = 2'b10;
                IR_WRITE   = MEM_READY;
                PC_WRITE   = MEM_READY;
                if (MEM_READY) state_d = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch/jump target into ALUOut
                ALU_SRC_A = 2'b01;
                ALU_SRC_B = 2'b01;
                unique case (OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        ILLEGAL = 1'b1;
                        RETIRE  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALU_SRC_A = 2'b10;
                ALU_SRC_B = 2'b01;
                state_d   = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ADR_SRC = 1'b1;
                if (MEM_READY) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                ADR_SRC   = 1'b1;
                MEM_WRITE = 1'b1;
                RETIRE    = MEM_READY;
                if (MEM_READY) state_d = S_FETCH;
            end
            S_MEMWB: begin
                RESULT_SRC = 2'b01;
                REG_WRITE  = 1'b1;
                RETIRE     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECR: begin
                ALU_SRC_A = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                ALU_SRC_A = 2'b10;
                ALU_SRC_B = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                REG_WRITE = 1'b1;
                RETIRE    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                ALU_SRC_A = 2'b10;
                alu_op    = 2'b01;
                PC_WRITE  = ZERO;
                RETIRE    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // Link value OldPC+4 goes through ALUOut; PC takes the target
                // computed in DECODE.
                ALU_SRC_A = 2'b01;
                ALU_SRC_B = 2'b10;
                PC_WRITE  = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
        if (!RST_N) begin
            PC_WRITE  = 1'b0;
            IR_WRITE  = 1'b0;
            MEM_WRITE = 1'b0;
            REG_WRITE = 1'b0;
            RETIRE    = 1'b0;
            ILLEGAL   = 1'b0;
        end
    end

    // ALU decoder
    always_comb begin
        ALU_CONTROL = 3'b000;
        unique case (alu_op)
            2'b01: ALU_CONTROL = 3'b001;
            2'b10: begin
                unique case (FUNCT3)
                    3'b000:  ALU_CONTROL = (OP[5] & FUNCT7B5) ? 3'b001 : 3'b000;
                    3'b010:  ALU_CONTROL = 3'b101;
                    3'b110:  ALU_CONTROL = 3'b011;
                    3'b111:  ALU_CONTROL = 3'b010;
                    default: ALU_CONTROL = 3'b000;
                endcase
            end
            default: ALU_CONTROL = 3'b000;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb begin
        unique case (OP)
            OP_SW:   IMM_SRC = 2'b01;
            OP_BEQ:  IMM_SRC = 2'b10;
            OP_JAL:  IMM_SRC = 2'b11;
            default: IMM_SRC = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller. For each
// instruction the bench builds the expected per-cycle output trace from the
// instruction class and the chosen wait-state counts, then drives the inputs
// cycle by cycle and compares all outputs.
module tb_multicycle_controller;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [6:0] OP;
    logic [2:0] FUNCT3;
    logic       FUNCT7B5, ZERO, MEM_READY;
    logic       PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE, RETIRE, ILLEGAL;
    logic [1:0] RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC;
    logic [2:0] ALU_CONTROL;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    multicycle_controller dut (
        .CLK(CLK), .RST_N(RST_N), .OP(OP), .FUNCT3(FUNCT3), .FUNCT7B5(FUNCT7B5),
        .ZERO(ZERO), .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .ADR_SRC(ADR_SRC),
        .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE), .REG_WRITE(REG_WRITE),
        .RESULT_SRC(RESULT_SRC), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
        .IMM_SRC(IMM_SRC), .ALU_CONTROL(ALU_CONTROL), .RETIRE(RETIRE), .ILLEGAL(ILLEGAL)
    );

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic       ret, ill;
        logic [1:0] imm;
    } vec_t;

    typedef struct packed {
        vec_t v;
        logic rdy, z;
    } step_t;

    vec_t obs;
    assign obs = {PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE, RESULT_SRC,
                  ALU_SRC_A, ALU_SRC_B, ALU_CONTROL, RETIRE, ILLEGAL, IMM_SRC};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pcw, adr, mw, irw, rw,
                                input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                input logic ret, ill, input logic [1:0] imm);
        vec_t v;
        v = {pcw, adr, mw, irw, rw, rs, sa, sb, alu, ret, ill, imm};
        return v;
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // Arithmetic-op selection for R/I execute: sub only for R-type add with bit 30
    function automatic logic [2:0] alu_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic step_t stp(input vec_t v, input logic rdy, input logic z);
        step_t s;
        s.v = v; s.rdy = rdy; s.z = z;
        return s;
    endfunction

    // Run one instruction: wf wait cycles in fetch, wm wait cycles in the
    // memory access, optional reset at trace index rst_at (-1 = none).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wm, input int rst_at);
        step_t q[$];
        logic [1:0] im;
        vec_t e;
        int k;
        im = imm_ref(op);
        for (int i = 0; i < wf; i++)
            q.push_back(stp(mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0,im), 1'b0, 1'($urandom)));
        q.push_back(stp(mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0,im), 1'b1, 1'($urandom)));
        if (!(op inside {LW, SW, RT, IT, BQ, JL})) begin
            q.push_back(stp(mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,1,1,im), 1'($urandom), 1'($urandom)));
        end else begin
            q.push_back(stp(mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0,im), 1'($urandom), 1'($urandom)));
            case (op)
                LW, SW: begin
                    q.push_back(stp(mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,im), 1'($urandom), 1'($urandom)));
                    if (op == LW) begin
                        for (int i = 0; i < wm; i++)
                            q.push_back(stp(mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,im), 1'b0, 1'($urandom)));
                        q.push_back(stp(mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,im), 1'b1, 1'($urandom)));
                        q.push_back(stp(mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,1,0,im), 1'($urandom), 1'($urandom)));
                    end else begin
                        for (int i = 0; i < wm; i++)
                            q.push_back(stp(mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0,im), 1'b0, 1'($urandom)));
                        q.push_back(stp(mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,1,0,im), 1'b1, 1'($urandom)));
                    end
                end
                RT, IT: begin
                    q.push_back(stp(mk(0,0,0,0,0,2'b00,2'b10,(op == IT) ? 2'b01 : 2'b00,
                                       alu_ref(op, f3, f7),0,0,im), 1'($urandom), 1'($urandom)));
                    q.push_back(stp(mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0,im), 1'($urandom), 1'($urandom)));
                end
                BQ: q.push_back(stp(mk(z,0,0,0,0,2'b00,2'b10,2'b00,3'b001,1,0,im), 1'($urandom), z));
                default: begin // jal
                    q.push_back(stp(mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0,im), 1'($urandom), 1'($urandom)));
                    q.push_back(stp(mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0,im), 1'($urandom), 1'($urandom)));
                end
            endcase
        end
        k = (rst_at >= q.size()) ? q.size() - 1 : rst_at;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            OP = op; FUNCT3 = f3; FUNCT7B5 = f7;
            MEM_READY = q[i].rdy; ZERO = q[i].z;
            RST_N = (i != k);
            #1;
            e = (i == k) ? mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0,im) : q[i].v;
            chk($sformatf("op%b f3=%0d c%0d%s", op, f3, i, (i == k) ? " rst" : ""), 32'(obs), 32'(e));
            chk("sel11", 32'(RESULT_SRC == 2'b11 || ALU_SRC_A == 2'b11 || ALU_SRC_B == 2'b11), 32'd0);
            if (i == k) break;
        end
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [6:0] op;
        ops = '{LW, SW, RT, IT, BQ, JL};
        RST_N = 1'b0; OP = RT; FUNCT3 = 3'b000; FUNCT7B5 = 1'b0; ZERO = 1'b0; MEM_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            MEM_READY = 1'($urandom);
            #1;
            chk("reset", 32'(obs), 32'(mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0,2'b00)));
        end
        // directed
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0, -1);   // add
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, -1);   // sub
        run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, -1);   // addi, bit30 set
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 2, -1);   // lw, 2 waits
        run_instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0, -1);   // beq taken
        run_instr(BQ, 3'b000, 1'b0, 1'b0, 0, 0, -1);   // beq not taken
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, -1);   // sw, 3 waits
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, 2);    // reset in MEMADR
        run_instr(JL, 3'b000, 1'b0, 1'b0, 1, 0, -1);
        // random
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 7'($urandom);
                if (op inside {LW, SW, RT, IT, BQ, JL}) op = 7'b0000000;
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1);
        end
        run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
